event_encoder4x2: RTL

Sequential 4-to-2 encoder, the inverse of our 2x4 decoder. It captures one-hot/multi-hot event pulses on d into sticky pending bits and drains them one at a time as binary codes q, using a valid/ready handshake. Source side: event lines from decoded peripherals. Sink side: any code consumer that may stall. Priority is either fixed or round-robin.

---
 rtl/encoder_pkg.sv | 14 +
 rtl/rr_priority_pick.sv | 43 ++++
 rtl/event_encoder4x2.sv | 113 +++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared types and constants for the event encoder and its arbiter helper.
package encoder_pkg;

  // Output-side state: IDLE has no code presented, HOLD presents q with valid=1.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Priority scheme selectors for PRIO_MODE / the picker mode input.
  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational request picker: fixed (highest index wins) or round-robin
// (search starts just after ptr and wraps). Kept standalone for reuse by arbiters.
module rr_priority_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         mode,
  output logic         any,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);
  import encoder_pkg::*;

  // Scan in reverse priority order so the last hit is the winner.
  always_comb begin
    logic [W-1:0] j;
    any = |req;
    idx = '0;
    j   = '0;
    if (mode == PRIO_RR[0]) begin
      // k = N maps to ptr itself (lowest priority); k = 1 is ptr+1 (highest).
      // N is a power of two, so W-bit addition wraps modulo N for free.
      for (int k = N; k >= 1; k--) begin
        j = ptr + W'(k);
        if (req[j]) idx = j;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) idx = W'(i);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_onehot
      assign onehot[gi] = any && (idx == W'(gi));
    end
  endgenerate

endmodule

// File: rtl/event_encoder4x2.sv
// Sequential N-to-W encoder: captures event pulses into sticky pending bits and
// drains them one code per handshake over a valid/ready interface.
module event_encoder4x2
  import encoder_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = 2,
  parameter int PRIO_MODE = PRIO_FIXED
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [N-1:0] d,
  output logic [W-1:0] q,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pending,
  output logic         overflow,
  output logic         idle
);

  state_e       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] q_q, q_d;
  logic         valid_q, valid_d;
  logic         overflow_q, overflow_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         sel_any;
  logic [W-1:0] sel_idx;
  logic [N-1:0] sel_onehot;
  logic         load;
  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;

  // Selection looks only at registered pending; same-cycle d is invisible.
  rr_priority_pick #(.N(N), .W(W)) u_pick (
    .req    (pending_q),
    .ptr    (ptr_q),
    .mode   (PRIO_MODE == PRIO_RR),
    .any    (sel_any),
    .idx    (sel_idx),
    .onehot (sel_onehot)
  );

  // Next-state, capture and load logic; set beats clear on the same line.
  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    valid_d    = valid_q;
    ptr_d      = ptr_q;
    load       = 1'b0;
    set_vec    = enable ? d : '0;

    case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          load    = 1'b1;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ready) begin
          if (sel_any) begin
            load = 1'b1;
          end else begin
            // q keeps its last value once the stream runs dry.
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      q_d   = sel_idx;
      ptr_d = sel_idx;
    end

    clr_vec    = load ? sel_onehot : '0;
    pending_d  = set_vec | (pending_q & ~clr_vec);
    // A collision with a line being loaded this cycle is a fresh request, not overflow.
    overflow_d = |(set_vec & pending_q & ~clr_vec);
  end

  // State and output registers; pointer resets to N-1 so RR starts at line 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      q_q        <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      ptr_q      <= W'(N - 1);
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      q_q        <= q_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      ptr_q      <= ptr_d;
    end
  end

  assign q        = q_q;
  assign valid    = valid_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;
  assign idle     = !valid_q && (pending_q == '0);

endmodule
